regfile_sb: RTL and testbench

Parametrised successor to the ARM core's register file: a NREGS×DATA_W general-purpose register file with NRD combinational read ports, one posedge write port with write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode (reads, issue marking) and writeback. It reports, for each read operand, whether a not-yet-written-back result is still outstanding, so the hazard unit can stall without tracking destinations itself.

---
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: NREGS x DATA_W register file with NRD combinational read ports,
// one posedge write port with write-to-read bypass, and a per-register
// pending-write scoreboard that reports outstanding writes per read operand.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4,
    parameter int NRD    = 2,
    parameter int PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_dest,
    output logic                  issue_ready,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_dest,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    output logic                  sb_err
);

    // One extra bit so NREGS == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W + 1)'(NREGS);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PEND_W-1:0] r_pend [NREGS];
    logic              r_sb_err;

    logic              w_wb_valid;
    logic              w_iss_valid;
    logic [PEND_W-1:0] w_wb_pend;
    logic [PEND_W-1:0] w_iss_pend;

    assign w_wb_valid  = {1'b0, wb_dest} < LP_NREGS;
    assign w_iss_valid = {1'b0, issue_dest} < LP_NREGS;

    // Pending counts of the writeback and issue targets (zero when out of range).
    always_comb begin
        w_wb_pend  = '0;
        w_iss_pend = '0;
        if (w_wb_valid) begin
            w_wb_pend = r_pend[wb_dest];
        end
        if (w_iss_valid) begin
            w_iss_pend = r_pend[issue_dest];
        end
    end

    assign issue_ready = !w_iss_valid || (w_iss_pend != '1);
    assign sb_err      = r_sb_err;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic              w_valid;
        logic              w_hit;
        logic              w_dec;
        logic [DATA_W-1:0] w_reg;
        logic [PEND_W-1:0] w_pend;

        assign w_a     = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_valid = {1'b0, w_a} < LP_NREGS;

        // Fetch stored value and pending count for this port's address.
        always_comb begin
            w_reg  = '0;
            w_pend = '0;
            if (w_valid) begin
                w_reg  = r_regs[w_a];
                w_pend = r_pend[w_a];
            end
        end

        assign w_hit = w_valid && wb_en && (wb_dest == w_a);
        assign w_dec = w_hit && (w_pend != '0);

        assign rd_data[k*DATA_W +: DATA_W] = !w_valid ? '0 : (w_hit ? wb_data : w_reg);
        // A writeback landing this cycle already covers one outstanding write.
        assign rd_busy[k] = w_valid && ((w_pend - PEND_W'(w_dec)) != '0);
    end

    // Register storage, scoreboard counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= DATA_W'(i);
                r_pend[i] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            if (wb_en && w_wb_valid) begin
                r_regs[wb_dest] <= wb_data;
                if ((w_wb_pend == '0) && !flush) begin
                    r_sb_err <= 1'b1;
                end
            end
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (flush) begin
                    r_pend[r] <= '0;
                end else begin
                    logic inc;
                    logic dec;
                    inc = issue_en && issue_ready && w_iss_valid && (issue_dest == ADDR_W'(r));
                    dec = wb_en && (wb_dest == ADDR_W'(r)) && (r_pend[r] != '0);
                    if (inc && !dec) begin
                        r_pend[r] <= r_pend[r] + 1'b1;
                    end else if (dec && !inc) begin
                        r_pend[r] <= r_pend[r] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven bench for regfile_sb with a queue of expected
// outputs pushed when each cycle's stimulus is driven and popped at sampling.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_en;
    logic [3:0]  issue_dest;
    logic        issue_ready;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        flush;
    logic        sb_err;

    regfile_sb #(
        .DATA_W(32),
        .NREGS (15),
        .ADDR_W(4),
        .NRD   (2),
        .PEND_W(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .issue_ready(issue_ready),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .flush      (flush),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic        ie;
        logic [3:0]  id;
        logic        we;
        logic [3:0]  wd;
        logic [31:0] wdata;
        logic        fl;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ebusy;
        logic        erdy;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic r, logic [3:0] a0, logic [3:0] a1,
                                logic ie, logic [3:0] id,
                                logic we, logic [3:0] wd, logic [31:0] wdata,
                                logic fl, logic [31:0] e0, logic [31:0] e1,
                                logic [1:0] eb, logic erdy, logic eerr);
        vec_t v;
        v.rst = r; v.a0 = a0; v.a1 = a1; v.ie = ie; v.id = id;
        v.we = we; v.wd = wd; v.wdata = wdata; v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.ebusy = eb; v.erdy = erdy; v.eerr = eerr;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectations, compare at negedge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst        = v.rst;
        rd_addr    = {v.a1, v.a0};
        issue_en   = v.ie;
        issue_dest = v.id;
        wb_en      = v.we;
        wb_dest    = v.wd;
        wb_data    = v.wdata;
        flush      = v.fl;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp("rd_data0", idx, rd_data[31:0], e.e0);
        cmp("rd_data1", idx, rd_data[63:32], e.e1);
        cmp("rd_busy", idx, {30'd0, rd_busy}, {30'd0, e.ebusy});
        cmp("issue_ready", idx, {31'd0, issue_ready}, {31'd0, e.erdy});
        cmp("sb_err", idx, {31'd0, sb_err}, {31'd0, e.eerr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; issue_en = 1'b0; issue_dest = '0;
        wb_en = 1'b0; wb_dest = '0; wb_data = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //            rst a0  a1  ie id  we wd  wdata          fl e0            e1            busy   rdy err
        // reset values
        tbl.push_back(mk(0, 3,  14, 0, 0,  0, 0,  32'h0,         0, 32'd3,        32'd14,       2'b00, 1, 0));
        // issue R5, busy next cycle, bypass clears busy
        tbl.push_back(mk(0, 5,  5,  1, 5,  0, 0,  32'h0,         0, 32'd5,        32'd5,        2'b00, 1, 0));
        tbl.push_back(mk(0, 5,  3,  0, 5,  0, 0,  32'h0,         0, 32'd5,        32'd3,        2'b01, 1, 0));
        tbl.push_back(mk(0, 5,  5,  0, 5,  1, 5,  32'hDEADBEEF,  0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0));
        tbl.push_back(mk(0, 5,  0,  0, 5,  0, 0,  32'h0,         0, 32'hDEADBEEF, 32'd0,        2'b00, 1, 0));
        // saturate R2, fourth issue dropped, three writebacks drain it
        tbl.push_back(mk(0, 2,  2,  1, 2,  0, 0,  32'h0,         0, 32'd2,        32'd2,        2'b00, 1, 0));
        tbl.push_back(mk(0, 2,  2,  1, 2,  0, 0,  32'h0,         0, 32'd2,        32'd2,        2'b11, 1, 0));
        tbl.push_back(mk(0, 2,  2,  1, 2,  0, 0,  32'h0,         0, 32'd2,        32'd2,        2'b11, 1, 0));
        tbl.push_back(mk(0, 2,  2,  1, 2,  0, 0,  32'h0,         0, 32'd2,        32'd2,        2'b11, 0, 0));
        tbl.push_back(mk(0, 2,  2,  0, 2,  1, 2,  32'h22,        0, 32'h22,       32'h22,       2'b11, 0, 0));
        tbl.push_back(mk(0, 2,  2,  0, 2,  1, 2,  32'h23,        0, 32'h23,       32'h23,       2'b11, 1, 0));
        tbl.push_back(mk(0, 2,  2,  0, 2,  1, 2,  32'h24,        0, 32'h24,       32'h24,       2'b00, 1, 0));
        tbl.push_back(mk(0, 2,  2,  0, 2,  0, 0,  32'h0,         0, 32'h24,       32'h24,       2'b00, 1, 0));
        // simultaneous issue and writeback on R7
        tbl.push_back(mk(0, 7,  7,  1, 7,  0, 0,  32'h0,         0, 32'd7,        32'd7,        2'b00, 1, 0));
        tbl.push_back(mk(0, 7,  7,  1, 7,  1, 7,  32'h77,        0, 32'h77,       32'h77,       2'b00, 1, 0));
        tbl.push_back(mk(0, 7,  7,  0, 7,  0, 0,  32'h0,         0, 32'h77,       32'h77,       2'b11, 1, 0));
        tbl.push_back(mk(0, 7,  7,  0, 7,  1, 7,  32'h78,        0, 32'h78,       32'h78,       2'b00, 1, 0));
        // flush with a concurrent writeback, then an unexpected writeback
        tbl.push_back(mk(0, 1,  4,  1, 1,  0, 0,  32'h0,         0, 32'd1,        32'd4,        2'b00, 1, 0));
        tbl.push_back(mk(0, 1,  4,  1, 4,  0, 0,  32'h0,         0, 32'd1,        32'd4,        2'b01, 1, 0));
        tbl.push_back(mk(0, 1,  4,  0, 4,  1, 4,  32'h55,        1, 32'd1,        32'h55,       2'b01, 1, 0));
        tbl.push_back(mk(0, 1,  4,  0, 4,  0, 0,  32'h0,         0, 32'd1,        32'h55,       2'b00, 1, 0));
        tbl.push_back(mk(0, 1,  4,  0, 4,  1, 1,  32'h11,        0, 32'h11,       32'h55,       2'b00, 1, 0));
        tbl.push_back(mk(0, 1,  4,  0, 4,  0, 0,  32'h0,         0, 32'h11,       32'h55,       2'b00, 1, 1));
        // out-of-range address 15
        tbl.push_back(mk(0, 15, 15, 1, 15, 1, 15, 32'hFFFFFFFF,  0, 32'd0,        32'd0,        2'b00, 1, 1));
        tbl.push_back(mk(0, 15, 14, 0, 15, 0, 0,  32'h0,         0, 32'd0,        32'd14,       2'b00, 1, 1));
        // issue during flush is ignored
        tbl.push_back(mk(0, 3,  3,  1, 3,  0, 0,  32'h0,         1, 32'd3,        32'd3,        2'b00, 1, 1));
        tbl.push_back(mk(0, 3,  3,  0, 3,  0, 0,  32'h0,         0, 32'd3,        32'd3,        2'b00, 1, 1));
        // reset mid-operation overrides issue and writeback
        tbl.push_back(mk(0, 6,  9,  1, 6,  1, 9,  32'h99,        0, 32'd6,        32'h99,       2'b00, 1, 1));
        tbl.push_back(mk(1, 6,  9,  1, 6,  1, 9,  32'hAA,        0, 32'd6,        32'hAA,       2'b01, 1, 1));
        tbl.push_back(mk(0, 6,  9,  0, 6,  0, 0,  32'h0,         0, 32'd6,        32'd9,        2'b00, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Sweep every address after the mid-operation reset.
        for (int a = 0; a < 16; a++) begin
            logic [3:0]  x0;
            logic [3:0]  x1;
            logic [31:0] d0;
            logic [31:0] d1;
            x0 = 4'(a);
            x1 = 4'(15 - a);
            d0 = (a < 15) ? 32'(a) : 32'd0;
            d1 = ((15 - a) < 15) ? 32'(15 - a) : 32'd0;
            apply(mk(0, x0, x1, 0, x0, 0, 0, 32'h0, 0, d0, d1, 2'b00, 1, 0), 100 + a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
